// File: rtl/yarp_fetch_if.sv
// ============================================================================
//  Module   : yarp_fetch_if
//  Purpose  : Fetch-stage bundle: redirect input, imem port and decode handoff.
//             fetch_misalign_o exists only with YARP_FETCH_MISALIGN_CHK_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface yarp_fetch_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
`ifdef YARP_FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign_o;

    modport master (
        input  redirect_i, redirect_pc_i, imem_ready_i, imem_rvalid_i,
               imem_rdata_i, instr_ready_i,
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
               fetch_misalign_o
    );
    modport slave (
        output redirect_i, redirect_pc_i, imem_ready_i, imem_rvalid_i,
               imem_rdata_i, instr_ready_i,
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
               fetch_misalign_o
    );
`else
    modport master (
        input  redirect_i, redirect_pc_i, imem_ready_i, imem_rvalid_i,
               imem_rdata_i, instr_ready_i,
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
    );
    modport slave (
        output redirect_i, redirect_pc_i, imem_ready_i, imem_rvalid_i,
               imem_rdata_i, instr_ready_i,
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o
    );
`endif
endinterface

`default_nettype wire

// File: rtl/yarp_fetch.sv
// ============================================================================
//  Module   : yarp_fetch
//  Purpose  : Single-outstanding instruction fetch stage with redirect/kill.
//             Optional misaligned-redirect trap: YARP_FETCH_MISALIGN_CHK_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module yarp_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
    input  logic         clk,
    input  logic         reset_n,
    yarp_fetch_if.master bus
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_kill;
    logic        r_req;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_ipc;
    logic [31:0] w_tgt;
`ifdef YARP_FETCH_MISALIGN_CHK_EN
    logic        r_misalign;
    logic        w_bad;
    logic        w_outstanding;

    assign w_tgt         = bus.redirect_pc_i;
    assign w_bad         = bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);
    // A request is in flight if accepted now, or accepted earlier and not yet answered
    assign w_outstanding = ((r_state == S_REQ)  && bus.imem_ready_i) ||
                           ((r_state == S_WAIT) && !bus.imem_rvalid_i);
`else
    assign w_tgt = bus.redirect_pc_i & ~32'h0000_0003;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_instr <= 32'h0;
            r_ipc   <= 32'h0;
`ifdef YARP_FETCH_MISALIGN_CHK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
`ifdef YARP_FETCH_MISALIGN_CHK_EN
            if (w_bad && (r_state != S_ERR)) begin
                r_misalign <= 1'b1;
                r_pc       <= w_tgt;
                r_req      <= 1'b0;
                r_valid    <= 1'b0;
                r_kill     <= w_outstanding;
                r_state    <= S_ERR;
            end else
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.redirect_i) r_pc <= w_tgt;
                    r_req   <= 1'b1;
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    // Address may move only while the request is still unaccepted
                    if (bus.redirect_i) r_pc <= w_tgt;
                    if (bus.imem_ready_i) begin
                        r_req   <= 1'b0;
                        r_kill  <= bus.redirect_i;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid_i) begin
                        if (r_kill || bus.redirect_i) begin
                            if (bus.redirect_i) r_pc <= w_tgt;
                            r_kill  <= 1'b0;
                            r_req   <= 1'b1;
                            r_state <= S_REQ;
                        end else begin
                            r_instr <= bus.imem_rdata_i;
                            r_ipc   <= r_pc;
                            r_valid <= 1'b1;
                            r_pc    <= r_pc + c_PC_STEP;
                            r_state <= S_HOLD;
                        end
                    end else if (bus.redirect_i) begin
                        r_kill <= 1'b1;
                        r_pc   <= w_tgt;
                    end
                end
                S_HOLD: begin
                    // Redirect outranks the decode handshake
                    if (bus.redirect_i) begin
                        r_pc    <= w_tgt;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end else if (bus.instr_ready_i) begin
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
`ifdef YARP_FETCH_MISALIGN_CHK_EN
                S_ERR: begin
                    if (r_kill && bus.imem_rvalid_i) r_kill <= 1'b0;
                end
`endif
                default: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req_o    = r_req;
    assign bus.imem_addr_o   = r_pc;
    assign bus.instr_valid_o = r_valid;
    assign bus.instr_o       = r_instr;
    assign bus.instr_pc_o    = r_ipc;
`ifdef YARP_FETCH_MISALIGN_CHK_EN
    assign bus.fetch_misalign_o = r_misalign;
`endif

endmodule

`default_nettype wire

// File: tb/tb_yarp_fetch.sv
// ============================================================================
//  Module   : tb_yarp_fetch
//  Purpose  : Self-checking bench for yarp_fetch against a transaction model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_yarp_fetch;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    yarp_fetch_if bus ();

    yarp_fetch #(.RESET_PC(32'h0000_1000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model of what the fetch unit owes its neighbours
    logic [31:0] exp_addr;
    logic        m_valid;
    logic [31:0] m_vpc;
    logic        pend;
    logic [31:0] pend_addr;
    logic        pend_kill;
    int          cnt;
    int          lat;
    logic        m_hold_req;
    logic [31:0] m_hold_addr;
    int          cyc;
    int          n_deliver;
    logic [31:0] acc_q[$];
    int          acc_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] t);
`ifdef YARP_FETCH_MISALIGN_CHK_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        bus.redirect_i = 1'b0;    bus.redirect_pc_i = 32'h0;
        bus.imem_ready_i = 1'b0;  bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = 32'h0; bus.instr_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req",   {31'h0, bus.imem_req_o},    32'h0);
        chk("rst_addr",  bus.imem_addr_o,            32'h0000_1000);
        chk("rst_valid", {31'h0, bus.instr_valid_o}, 32'h0);
        chk("rst_instr", bus.instr_o,                32'h0);
        chk("rst_ipc",   bus.instr_pc_o,             32'h0);
`ifdef YARP_FETCH_MISALIGN_CHK_EN
        chk("rst_mis",   {31'h0, bus.fetch_misalign_o}, 32'h0);
`endif
        exp_addr = 32'h0000_1000;
        m_valid = 1'b0; m_vpc = 32'h0;
        pend = 1'b0; pend_kill = 1'b0; pend_addr = 32'h0; cnt = 0;
        m_hold_req = 1'b0; m_hold_addr = 32'h0;
        acc_q.delete(); acc_cyc.delete();
        reset_n = 1'b1;
    endtask

    // One clock: check what the last edge produced, then drive and predict the next edge
    task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt, input bit irdy);
        logic rv;
        logic nv;
        @(negedge clk);
        cyc++;
        chk("valid", {31'h0, bus.instr_valid_o}, {31'h0, m_valid});
        if (m_valid) begin
            chk("instr_pc", bus.instr_pc_o, m_vpc);
            chk("instr",    bus.instr_o,    memf(m_vpc));
        end
        if (m_hold_req) begin
            chk("req_hold",  {31'h0, bus.imem_req_o}, 32'h1);
            chk("addr_hold", bus.imem_addr_o,         m_hold_addr);
        end
        rv = pend && (cnt == 0);
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rv ? memf(pend_addr) : $urandom;
        bus.imem_ready_i  = rdy;
        bus.redirect_i    = redir;
        bus.redirect_pc_i = tgt;
        bus.instr_ready_i = irdy;

        nv = m_valid && !irdy && !redir;
        if (pend) begin
            if (rv) begin
                pend = 1'b0;
                if (!pend_kill && !redir) begin
                    nv = 1'b1;
                    m_vpc = pend_addr;
                    exp_addr = pend_addr + 32'd4;
                    n_deliver++;
                end
            end else begin
                cnt--;
            end
        end
        if (bus.imem_req_o && rdy) begin
            chk("acc_addr", bus.imem_addr_o, exp_addr);
            acc_q.push_back(bus.imem_addr_o);
            acc_cyc.push_back(cyc);
            pend = 1'b1; pend_addr = bus.imem_addr_o; pend_kill = 1'b0; cnt = lat;
        end
        if (redir) begin
            exp_addr = align(tgt);
            if (pend) pend_kill = 1'b1;
        end
        m_hold_req  = bus.imem_req_o && !rdy && !redir;
        m_hold_addr = bus.imem_addr_o;
        m_valid     = nv;
    endtask

    initial begin
        int c;
        int i;
        cyc = 0; n_deliver = 0; lat = 0;
        do_reset();

        // Zero-wait memory, decode always ready
        repeat (12) step(1, 0, 32'h0, 1);
        chk("first_addr",  acc_q[0], 32'h0000_1000);
        chk("second_addr", acc_q[1], 32'h0000_1004);
        chk("third_addr",  acc_q[2], 32'h0000_1008);
        chk("spacing_a",   acc_cyc[1] - acc_cyc[0], 3);
        chk("spacing_b",   acc_cyc[2] - acc_cyc[1], 3);

        // Memory stalls, then redirect while waiting for 0x1004
        do_reset();
        repeat (6) step(0, 0, 32'h0, 1);
        lat = 3;
        for (i = 0; i < 40 && !(pend && pend_addr == 32'h0000_1004); i++) step(1, 0, 32'h0, 1);
        chk("reach_wait1004", {31'h0, pend}, 32'h1);
        step(0, 1, 32'h0000_2000, 1);
        for (i = 0; i < 40 && !(m_valid && m_vpc == 32'h0000_2000); i++) step(1, 0, 32'h0, 1);
        @(posedge clk); #1;
        chk("redir_ipc", bus.instr_pc_o, 32'h0000_2000);

        // Stall in HOLD, then redirect together with decode-ready
        lat = 0;
        for (i = 0; i < 40 && !m_valid; i++) step(1, 0, 32'h0, 0);
        repeat (4) step(1, 0, 32'h0, 0);
        step(1, 1, 32'h0000_3000, 1);
        c = acc_q.size();
        for (i = 0; i < 20 && acc_q.size() <= c; i++) step(1, 0, 32'h0, 1);
        chk("hold_redir", (acc_q.size() > c) ? acc_q[c] : 32'hDEAD_BEEF, 32'h0000_3000);

        // PC wrap
        for (i = 0; i < 40 && !m_valid; i++) step(1, 0, 32'h0, 0);
        step(1, 1, 32'hFFFF_FFFC, 1);
        c = acc_q.size();
        for (i = 0; i < 30 && acc_q.size() < c + 2; i++) step(1, 0, 32'h0, 1);
        chk("wrap_a", (acc_q.size() > c)     ? acc_q[c]     : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk("wrap_b", (acc_q.size() > c + 1) ? acc_q[c + 1] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] t;
            t = $urandom;
`ifdef YARP_FETCH_MISALIGN_CHK_EN
            t[1:0] = 2'b00;
`endif
            lat = $urandom_range(0, 3);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, t,
                 $urandom_range(0, 2) != 0);
        end
        chk("deliveries", {31'h0, n_deliver > 100}, 32'h1);

        // Misaligned redirect
        lat = 1;
        step(1, 1, 32'h0000_2002, 1);
        c = acc_q.size();
`ifdef YARP_FETCH_MISALIGN_CHK_EN
        @(posedge clk); #1;
        chk("misalign", {31'h0, bus.fetch_misalign_o}, 32'h1);
        for (i = 0; i < 6; i++) begin
            step(1, 0, 32'h0, 1);
            @(posedge clk); #1;
            chk("err_noreq", {31'h0, bus.imem_req_o}, 32'h0);
        end
        chk("err_noacc", acc_q.size() - c, 0);
`else
        for (i = 0; i < 20 && acc_q.size() <= c; i++) step(1, 0, 32'h0, 1);
        chk("unalign_fetch", (acc_q.size() > c) ? acc_q[c] : 32'hDEAD_BEEF, 32'h0000_2000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
